// File: rtl/led_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_status_pkg
//  Purpose  : Shared types and helpers for the multi-channel LED driver.
//  Revision : 1.0 - initial release
// ============================================================================
package led_status_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CODE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        C_ON  = 2'd0,
        C_OFF = 2'd1,
        C_GAP = 2'd2
    } code_state_e;

    // Prescaler divide ratio, never below 1.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        int d;
        d = (tick_hz > 0) ? (clk_hz / tick_hz) : 1;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Terminal count for a duration of n ticks (0 is treated as 1).
    function automatic int last_idx(input int n);
        return (n < 1) ? 0 : n - 1;
    endfunction

endpackage : led_status_pkg
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
//  Module   : led_channel
//  Purpose  : One LED channel: mode/arg registers, phase counter, CODE FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module led_channel
    import led_status_pkg::*;
#(
    parameter int   ARG_W     = 12,
    parameter int   RST_HALF  = 500,
    parameter int   CODE_ON   = 200,
    parameter int   CODE_OFF  = 200,
    parameter int   CODE_GAP  = 1000,
    parameter logic RST_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_restart,
    input  logic             i_wr_en,
    input  mode_e            i_wr_mode,
    input  logic [ARG_W-1:0] i_wr_arg,
    output logic             o_level
);

    localparam int c_CW = max_int(ARG_W,
                          $clog2(max_int(max_int(CODE_ON, CODE_OFF), CODE_GAP) + 1));
    localparam logic [c_CW-1:0] c_ON_LAST  = c_CW'(last_idx(CODE_ON));
    localparam logic [c_CW-1:0] c_OFF_LAST = c_CW'(last_idx(CODE_OFF));
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(last_idx(CODE_GAP));

    mode_e            r_mode;
    logic [ARG_W-1:0] r_arg;
    logic [c_CW-1:0]  r_cnt;
    logic [ARG_W-1:0] r_pulse;
    code_state_e      r_cstate;
    logic             r_level;

    mode_e            w_mode;
    logic [ARG_W-1:0] w_arg;
    logic [c_CW-1:0]  w_blink_last;
    logic [c_CW-1:0]  w_cnt_inc;

    // A restart without a write (SYNC) keeps the current mode and argument.
    assign w_mode       = i_wr_en ? i_wr_mode : r_mode;
    assign w_arg        = i_wr_en ? i_wr_arg  : r_arg;
    assign w_blink_last = (r_arg == '0) ? '0 : c_CW'(r_arg - 1'b1);
    assign w_cnt_inc    = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_BLINK;
            r_arg    <= ARG_W'(RST_HALF);
            r_cnt    <= '0;
            r_pulse  <= '0;
            r_cstate <= C_ON;
            r_level  <= RST_LEVEL;
        end else if (i_restart) begin
            r_mode   <= w_mode;
            r_arg    <= w_arg;
            r_cnt    <= '0;
            r_pulse  <= '0;
            r_cstate <= C_ON;
            case (w_mode)
                MODE_OFF:   r_level <= 1'b0;
                MODE_ON:    r_level <= 1'b1;
                MODE_BLINK: r_level <= i_wr_en ? 1'b1 : RST_LEVEL;
                MODE_CODE: begin
                    // A zero pulse count parks the FSM dark in the gap state.
                    if (w_arg == '0) begin
                        r_cstate <= C_GAP;
                        r_level  <= 1'b0;
                    end else begin
                        r_level  <= 1'b1;
                    end
                end
                default:    r_level <= 1'b0;
            endcase
        end else if (i_tick) begin
            case (r_mode)
                MODE_BLINK: begin
                    if (r_cnt == w_blink_last) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                MODE_CODE: begin
                    if (r_arg != '0) begin
                        case (r_cstate)
                            C_ON: begin
                                if (r_cnt == c_ON_LAST) begin
                                    r_cstate <= C_OFF;
                                    r_level  <= 1'b0;
                                    r_cnt    <= '0;
                                    r_pulse  <= r_pulse + 1'b1;
                                end else begin
                                    r_cnt    <= w_cnt_inc;
                                end
                            end
                            C_OFF: begin
                                if (r_cnt == c_OFF_LAST) begin
                                    r_cnt <= '0;
                                    if (r_pulse == r_arg) begin
                                        r_cstate <= C_GAP;
                                    end else begin
                                        r_cstate <= C_ON;
                                        r_level  <= 1'b1;
                                    end
                                end else begin
                                    r_cnt <= w_cnt_inc;
                                end
                            end
                            C_GAP: begin
                                if (r_cnt == c_GAP_LAST) begin
                                    r_cstate <= C_ON;
                                    r_level  <= 1'b1;
                                    r_cnt    <= '0;
                                    r_pulse  <= '0;
                                end else begin
                                    r_cnt    <= w_cnt_inc;
                                end
                            end
                            default: begin
                                r_cstate <= C_GAP;
                                r_level  <= 1'b0;
                                r_cnt    <= '0;
                            end
                        endcase
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_level = r_level;

endmodule : led_channel
`default_nettype wire

// File: rtl/led_status_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_status_ctrl
//  Purpose  : Multi-channel LED indicator driver with shared tick prescaler.
//  Revision : 1.0 - initial release
// ============================================================================
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int                  NUM_LEDS   = 2,
    parameter int                  CLK_HZ     = 78_000_000,
    parameter int                  TICK_HZ    = 1000,
    parameter int                  ARG_W      = 12,
    parameter int                  RST_HALF   = 500,
    parameter int                  CODE_ON    = 200,
    parameter int                  CODE_OFF   = 200,
    parameter int                  CODE_GAP   = 1000,
    parameter logic [NUM_LEDS-1:0] ACTIVE_LOW = {NUM_LEDS{1'b0}}
) (
    input  logic                CLKOS,
    input  logic                Reset,
    input  logic                SYNC,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [ARG_W-1:0]    cfg_arg,
    output logic                cfg_err,
    output logic                tick,
    output logic [NUM_LEDS-1:0] LED
);

    localparam int              c_DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam int              c_PW       = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_PW-1:0] c_DIV_LAST = c_PW'(c_DIV - 1);

    logic [c_PW-1:0]     r_presc;
    logic                r_tick;
    logic                r_ready;
    logic                r_err;

    logic [c_PW-1:0]     w_presc_nxt;
    logic                w_accept;
    logic                w_chan_bad;
    logic [NUM_LEDS-1:0] w_wr_en;
    logic [NUM_LEDS-1:0] w_restart;
    logic [NUM_LEDS-1:0] w_level;

    assign w_presc_nxt = SYNC ? '0 :
                         (r_presc == c_DIV_LAST) ? '0 : r_presc + 1'b1;
    assign w_accept    = cfg_valid & r_ready;
    assign w_chan_bad  = ({1'b0, cfg_chan} >= 5'(NUM_LEDS));

    // tick is registered so it is high exactly while the count sits at DIV-1.
    always_ff @(posedge CLKOS) begin
        if (Reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == c_DIV_LAST);
            r_ready <= 1'b1;
            r_err   <= w_accept & w_chan_bad;
        end
    end

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
            assign w_wr_en[i]   = w_accept & (cfg_chan == 4'(i));
            assign w_restart[i] = w_wr_en[i] | SYNC;

            led_channel #(
                .ARG_W     (ARG_W),
                .RST_HALF  (RST_HALF),
                .CODE_ON   (CODE_ON),
                .CODE_OFF  (CODE_OFF),
                .CODE_GAP  (CODE_GAP),
                .RST_LEVEL ((i % 2) == 0)
            ) u_chan (
                .clk       (CLKOS),
                .rst       (Reset),
                .i_tick    (r_tick),
                .i_restart (w_restart[i]),
                .i_wr_en   (w_wr_en[i]),
                .i_wr_mode (mode_e'(cfg_mode)),
                .i_wr_arg  (cfg_arg),
                .o_level   (w_level[i])
            );
        end
    endgenerate

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = r_tick;
    assign LED       = w_level ^ ACTIVE_LOW;

endmodule : led_status_ctrl
`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_status_ctrl
//  Purpose  : Self-checking bench for led_status_ctrl against a tick-time model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_ctrl;

    localparam int NL       = 2;
    localparam int CLK_HZ   = 10_000;
    localparam int TICK_HZ  = 1000;
    localparam int DIV      = 10;
    localparam int ARG_W    = 12;
    localparam int RST_HALF = 5;
    localparam int CODE_ON  = 2;
    localparam int CODE_OFF = 2;
    localparam int CODE_GAP = 6;
    localparam logic [NL-1:0] ACT_LOW = '0;

    logic             CLKOS     = 1'b0;
    logic             Reset     = 1'b1;
    logic             SYNC      = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [3:0]       cfg_chan  = '0;
    logic [1:0]       cfg_mode  = '0;
    logic [ARG_W-1:0] cfg_arg   = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic [NL-1:0]    LED;

    led_status_ctrl #(
        .NUM_LEDS   (NL),
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .ARG_W      (ARG_W),
        .RST_HALF   (RST_HALF),
        .CODE_ON    (CODE_ON),
        .CODE_OFF   (CODE_OFF),
        .CODE_GAP   (CODE_GAP),
        .ACTIVE_LOW (ACT_LOW)
    ) dut (
        .CLKOS     (CLKOS),
        .Reset     (Reset),
        .SYNC      (SYNC),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_arg   (cfg_arg),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .LED       (LED)
    );

    always #5 CLKOS = ~CLKOS;

    int errors = 0;
    int checks = 0;

    // Model: each channel's level is a pure function of ticks since its last restart.
    int m_cnt;
    bit m_ready;
    bit m_err;
    int m_mode  [NL];
    int m_arg   [NL];
    int m_t     [NL];
    bit m_start [NL];

    function automatic bit m_level(input int ch);
        int h, burst, p;
        case (m_mode[ch])
            0: return 1'b0;
            1: return 1'b1;
            2: begin
                h = (m_arg[ch] == 0) ? 1 : m_arg[ch];
                return m_start[ch] ^ bit'((m_t[ch] / h) % 2);
            end
            default: begin
                if (m_arg[ch] == 0) return 1'b0;
                burst = m_arg[ch] * (CODE_ON + CODE_OFF);
                p = m_t[ch] % (burst + CODE_GAP);
                if (p < burst) return ((p % (CODE_ON + CODE_OFF)) < CODE_ON);
                return 1'b0;
            end
        endcase
    endfunction

    function automatic logic [NL-1:0] model_led();
        logic [NL-1:0] v;
        for (int ch = 0; ch < NL; ch++) v[ch] = m_level(ch);
        return v ^ ACT_LOW;
    endfunction

    task automatic model_edge();
        bit tk, acc;
        tk  = (m_cnt == DIV - 1);
        acc = cfg_valid && m_ready;
        if (Reset) begin
            m_cnt = 0; m_ready = 0; m_err = 0;
            for (int ch = 0; ch < NL; ch++) begin
                m_mode[ch] = 2; m_arg[ch] = RST_HALF; m_t[ch] = 0;
                m_start[ch] = (ch % 2 == 0);
            end
        end else begin
            m_err = acc && (int'(cfg_chan) >= NL);
            for (int ch = 0; ch < NL; ch++) begin
                if (acc && int'(cfg_chan) == ch) begin
                    m_mode[ch] = int'(cfg_mode); m_arg[ch] = int'(cfg_arg);
                    m_t[ch] = 0; m_start[ch] = 1'b1;
                end else if (SYNC) begin
                    m_t[ch] = 0; m_start[ch] = (ch % 2 == 0);
                end else if (tk) begin
                    m_t[ch]++;
                end
            end
            m_cnt   = SYNC ? 0 : (m_cnt + 1) % DIV;
            m_ready = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLKOS);
        model_edge();
        @(negedge CLKOS);
        chk("led",       32'(LED),       32'(model_led()));
        chk("tick",      32'(tick),      32'(m_cnt == DIV - 1));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic do_write(input int ch, input int mode, input int arg);
        cfg_valid = 1'b1;
        cfg_chan  = 4'(ch);
        cfg_mode  = 2'(mode);
        cfg_arg   = ARG_W'(arg);
        cycle();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]       chan;
        logic [1:0]       mode;
        logic [ARG_W-1:0] arg;
        logic             exp_err;
        logic             exp_lvl;
    } vec_t;

    vec_t vt [8];

    initial begin
        int first_tick, first_tog, toggles, high, k;
        logic prev;

        vt[0] = '{4'd0,  2'd1, 12'd0, 1'b0, 1'b1};
        vt[1] = '{4'd1,  2'd0, 12'd0, 1'b0, 1'b0};
        vt[2] = '{4'd5,  2'd1, 12'd0, 1'b1, 1'b0};
        vt[3] = '{4'd1,  2'd3, 12'd2, 1'b0, 1'b1};
        vt[4] = '{4'd0,  2'd2, 12'd7, 1'b0, 1'b1};
        vt[5] = '{4'd15, 2'd0, 12'd0, 1'b1, 1'b0};
        vt[6] = '{4'd1,  2'd3, 12'd0, 1'b0, 1'b0};
        vt[7] = '{4'd0,  2'd0, 12'd0, 1'b0, 1'b0};

        // Reset state and free-running 1 Hz complementary pair.
        Reset = 1'b1;
        cycle();
        cycle();
        chk("reset_led", 32'(LED), 32'h1);
        Reset = 1'b0;
        first_tick = -1;
        first_tog  = -1;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            if (tick === 1'b1 && first_tick < 0) first_tick = i;
            if (LED[0] !== 1'b1 && first_tog < 0) first_tog = i;
        end
        chk("first_tick", 32'(first_tick), 32'd9);
        chk("first_toggle", 32'(first_tog), 32'd50);

        // BLINK with arg 0 toggles on every tick.
        do_write(0, 2, 0);
        prev = LED[0];
        toggles = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (LED[0] !== prev) toggles++;
            prev = LED[0];
        end
        chk("blink0_toggles", 32'(toggles), 32'd10);
        do_write(0, 0, 0);
        chk("off_led0", 32'(LED[0]), 32'd0);
        for (int i = 0; i < 30; i++) cycle();

        // CODE burst of three pulses: 60 high cycles per 180-cycle period.
        do_write(1, 3, 3);
        high = (LED[1] === 1'b1) ? 1 : 0;
        for (int i = 1; i < 180; i++) begin
            cycle();
            if (LED[1] === 1'b1) high++;
        end
        chk("code3_high_cycles", 32'(high), 32'd60);
        do_write(1, 3, 0);
        high = (LED[1] === 1'b1) ? 1 : 0;
        for (int i = 1; i < 100; i++) begin
            cycle();
            if (LED[1] === 1'b1) high++;
        end
        chk("code0_high_cycles", 32'(high), 32'd0);

        // Table of single writes, including out-of-range channels.
        for (int v = 0; v < 8; v++) begin
            do_write(int'(vt[v].chan), int'(vt[v].mode), int'(vt[v].arg));
            chk("vec_err", 32'(cfg_err), 32'(vt[v].exp_err));
            if (!vt[v].exp_err) chk("vec_led", 32'(LED[vt[v].chan[0]]), 32'(vt[v].exp_lvl));
            cycle();
            chk("vec_err_clear", 32'(cfg_err), 32'd0);
            for (int i = 0; i < 13; i++) cycle();
        end

        // SYNC together with a ch0 write.
        do_write(1, 2, 5);
        for (int i = 0; i < 7; i++) cycle();
        SYNC = 1'b1;
        do_write(0, 1, 0);
        SYNC = 1'b0;
        chk("sync_led0", 32'(LED[0]), 32'd1);
        chk("sync_led1", 32'(LED[1]), 32'd0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (tick === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("sync_tick_delay", 32'(k), 32'd9);
        for (int i = 0; i < 60; i++) cycle();

        // Reset in the middle of a CODE burst, with a write presented during reset.
        do_write(1, 3, 3);
        for (int i = 0; i < 45; i++) cycle();
        Reset = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_mode = 2'd0; cfg_arg = '0;
        cycle();
        chk("rst_mid_led", 32'(LED), 32'h1);
        chk("rst_mid_ready", 32'(cfg_ready), 32'd0);
        cycle();
        Reset = 1'b0;
        cfg_valid = 1'b0;
        cycle();
        chk("post_rst_led0", 32'(LED[0]), 32'd1);
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15))
                                                    : 4'($urandom_range(0, 1));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_arg   = ARG_W'($urandom_range(0, 4));
            SYNC      = ($urandom_range(0, 39) == 0);
            Reset     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        cfg_valid = 1'b0;
        SYNC      = 1'b0;
        Reset     = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_status_ctrl
`default_nettype wire

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised multi-channel LED indicator driver; successor to the single-pair 1 Hz blinker.
- Runs on the PLL output clock, with a prescaler shared by all channels.
- Each channel runs independently in OFF, ON, BLINK (programmable half-period) or CODE (N pulses, then a gap, repeating) mode.
- A valid/ready write port sets channel modes at runtime; a SYNC input realigns all channel phases.

Parameters:
- NUM_LEDS, 2, number of LED channels (1..16).
- CLK_HZ, 78_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, rate of the internal time base; DIV = CLK_HZ/TICK_HZ, minimum 1.
- ARG_W, 12, width of per-channel argument (half-period in ticks, or pulse count).
- RST_HALF, 500, BLINK half-period loaded at reset (1 Hz at the default tick).
- CODE_ON, 200, ON time of one CODE pulse, in ticks.
- CODE_OFF, 200, OFF time between CODE pulses, in ticks.
- CODE_GAP, 1000, OFF gap after the last pulse of a CODE burst, in ticks.
- ACTIVE_LOW, {NUM_LEDS{1'b0}}, per-channel output inversion mask.

Ports:
- CLKOS  in  1  PLL output clock; only clock domain.
- Reset  in  1  synchronous, active-high reset.
- SYNC  in  1  one-cycle pulse; restarts all channel phases.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when valid && ready.
- cfg_chan  in  4  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=CODE.
- cfg_arg  in  ARG_W  BLINK: half-period in ticks; CODE: pulse count.
- cfg_err  out  1  one-cycle pulse when a write targets cfg_chan >= NUM_LEDS.
- tick  out  1  one-cycle time-base pulse, for debug.
- LED  out  NUM_LEDS  LED drive, after ACTIVE_LOW inversion.

Behaviour:
- Clock and reset: one clock (CLKOS); synchronous active-high Reset; every register is reset on the CLKOS edge while Reset=1.
- Reset values:
  - Prescaler = 0; tick = 0; cfg_err = 0; cfg_ready = 0 during reset, 1 from the first cycle after.
  - Every channel: mode = BLINK, arg = RST_HALF, phase counter = 0.
  - Logical LED level: 1 for even channel index, 0 for odd (complementary pair at power-up).
  - LED = logical level ^ ACTIVE_LOW.
- Prescaler: counts 0..DIV-1. tick = 1 for the cycle where count == DIV-1, then count wraps to 0. With DIV=1, tick is constantly 1.
- Config write: accepted in cycle T when cfg_valid && cfg_ready. cfg_ready is 1 in every non-reset cycle.
  - Valid channel: mode and arg register at T+1; channel phase restarts at T+1 (see per-mode start state); logical level takes its start value at T+1.
  - Invalid channel: no state change; cfg_err = 1 at T+1 only.
  - Writes to the same channel in consecutive cycles are both applied in order.
- Per-channel state advances only on tick cycles, except on config restart or SYNC.
- OFF: logical level 0. ON: logical level 1. Phase counter held at 0 in both.
- BLINK: start level 1, counter 0.
  - On each tick: if counter == max(arg,1)-1, toggle level and clear counter; else increment counter.
  - arg = 0 behaves as arg = 1 (toggle every tick).
- CODE: per-channel FSM with states C_ON, C_OFF, C_GAP, plus tick counter and pulse counter.
  - Start: C_ON, level 1, both counters 0.
  - C_ON: after CODE_ON ticks, go to C_OFF with level 0; increment pulse count.
  - C_OFF: after CODE_OFF ticks, if pulse count == arg go to C_GAP, else C_ON with level 1.
  - C_GAP: after CODE_GAP ticks, go to C_ON with level 1; pulse count = 0.
  - arg = 0: FSM held in C_GAP, level 0 permanently.
- SYNC:
  - Every channel restarts its phase as on a config write with unchanged mode and arg.
  - For BLINK, SYNC also applies the even/odd start level used at reset.
  - Prescaler cleared to 0.
  - SYNC coincident with a config write: the write applies and that channel uses the write's start state.
- Reset mid-operation: all state returns to reset values on the next edge, and any write presented during reset is dropped.
- Counter widths: prescaler $clog2(DIV); phase counter ARG_W bits, or wide enough for CODE_GAP, whichever is larger. No overflow is possible because the counters compare against their limits.

Decomposition:
- Package led_status_pkg holds:
  - mode enum (OFF/ON/BLINK/CODE);
  - CODE FSM state enum (C_ON/C_OFF/C_GAP);
  - the DIV calculation function.
- Sub-module led_channel: one channel's mode/arg registers, phase counter and CODE FSM. Inputs are tick, restart, and the write data.
- Top level holds the prescaler, write decode, cfg_err, SYNC fan-out and ACTIVE_LOW inversion, and instantiates led_channel through a generate loop.

Test Plan (bench uses CLK_HZ=10_000, TICK_HZ=1000, so DIV=10):
- Reset released, RST_HALF=5, 200 cycles: tick every 10 cycles; LED[0] starts 1 and toggles every 50 cycles; LED[1] is always the complement of LED[0].
- Write ch0 BLINK arg=0: LED[0] toggles on every tick, i.e. every 10 cycles; write ch0 OFF: LED[0]=0 from T+1 and stays 0.
- Write ch1 CODE arg=3 with CODE_ON=2, CODE_OFF=2, CODE_GAP=6: three 20-cycle high pulses separated by 20-cycle lows, then a 60-cycle low gap, then the burst repeats. Then write arg=0: LED[1] stays 0.
- Write with cfg_chan=5: cfg_err is high exactly one cycle; no LED change; cfg_ready stays 1.
- SYNC pulse in the same cycle as a ch0 ON write: ch0 goes high at T+1; ch1 in BLINK restarts at level 0 with counter 0; prescaler count is 0 at T+1.
- Reset asserted mid-CODE burst: at the next edge all channels show the reset state (BLINK, LED[0]=1, LED[1]=0), and a write issued during reset has no effect.
